// File: rtl/neighbor_window_gen.sv
// Game-of-Life neighbour-window producer: loads a ROWSxCOLS board serially, then streams every
// cell with its 8-neighbour vector. Define TORUS_WRAP_EN for toroidal edges (default: dead border).
module neighbor_window_gen #(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cell_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    center,
  output logic [7:0]              neighbors,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done
);

  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int NCELLS = ROWS * COLS;
  localparam int IW     = $clog2(NCELLS);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    DONE
  } state_t;

  state_t            state_q;
  logic [NCELLS-1:0] board_q;
  logic [RW-1:0]     load_row_q;
  logic [CW-1:0]     load_col_q;
  logic [RW-1:0]     out_row_q;
  logic [CW-1:0]     out_col_q;
  logic              center_q;
  logic [7:0]        nbr_q;
  logic              out_valid_q;
  logic              frame_done_q;
  logic              in_ready_q;

  logic [RW-1:0]     sel_row_d;
  logic [CW-1:0]     sel_col_d;
  logic              center_d;
  logic [7:0]        nbr_d;
  logic [IW-1:0]     load_idx_d;
  logic              scan_adv_d;
  logic              scan_last_d;

  // Board bit at (r, c); r and c may lie one step outside the board.
  function automatic logic cell_at(input logic [NCELLS-1:0] b, input int r, input int c);
    int rr;
    int cc;
    rr = r;
    cc = c;
`ifdef TORUS_WRAP_EN
    if (rr < 0)          rr = ROWS - 1;
    else if (rr >= ROWS) rr = 0;
    if (cc < 0)          cc = COLS - 1;
    else if (cc >= COLS) cc = 0;
    return b[IW'(rr * COLS + cc)];
`else
    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
    return b[IW'(rr * COLS + cc)];
`endif
  endfunction

  // Select the cell to present next: (0,0) when nothing is shown yet, else the raster successor.
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    sel_row_d = '0;
    sel_col_d = '0;
    if (out_valid_q) begin
      if (out_col_q == COL_LAST) begin
        sel_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ROW_ONE;
      end else begin
        sel_row_d = out_row_q;
        sel_col_d = out_col_q + COL_ONE;
      end
    end

    center_d = cell_at(board_q, int'(sel_row_d), int'(sel_col_d));
    nbr_d = {
      cell_at(board_q, int'(sel_row_d) + 1, int'(sel_col_d) + 1),  // SE
      cell_at(board_q, int'(sel_row_d) + 1, int'(sel_col_d)),      // S
      cell_at(board_q, int'(sel_row_d) + 1, int'(sel_col_d) - 1),  // SW
      cell_at(board_q, int'(sel_row_d),     int'(sel_col_d) + 1),  // E
      cell_at(board_q, int'(sel_row_d),     int'(sel_col_d) - 1),  // W
      cell_at(board_q, int'(sel_row_d) - 1, int'(sel_col_d) + 1),  // NE
      cell_at(board_q, int'(sel_row_d) - 1, int'(sel_col_d)),      // N
      cell_at(board_q, int'(sel_row_d) - 1, int'(sel_col_d) - 1)   // NW
    };

    load_idx_d  = IW'(int'(load_row_q) * COLS + int'(load_col_q));
    scan_adv_d  = !out_valid_q || out_ready;
    scan_last_d = out_valid_q && (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
  end

  // NOTE: the board is a flop array rather than a RAM, so reset can clear it in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      board_q      <= '0;
      load_row_q   <= '0;
      load_col_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      center_q     <= 1'b0;
      nbr_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking updates, so every branch below sees the pre-edge register values.
      frame_done_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            board_q[load_idx_d] <= cell_in;
            if (load_col_q == COL_LAST) begin
              load_col_q <= '0;
              if (load_row_q == ROW_LAST) begin
                load_row_q <= '0;
                in_ready_q <= 1'b0;
                state_q    <= SCAN;
              end else begin
                load_row_q <= load_row_q + ROW_ONE;
              end
            end else begin
              load_col_q <= load_col_q + COL_ONE;
            end
          end
        end

        SCAN: begin
          if (scan_adv_d) begin
            if (scan_last_d) begin
              out_valid_q  <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              out_row_q   <= sel_row_d;
              out_col_q   <= sel_col_d;
              center_q    <= center_d;
              nbr_q       <= nbr_d;
              out_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          in_ready_q <= 1'b1;
          state_q    <= LOAD;
        end

        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= LOAD;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign center     = center_q;
  assign neighbors  = nbr_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_neighbor_window_gen.sv
// Scoreboard bench for neighbor_window_gen: random and directed boards, expected windows computed
// from a 2-D array model and checked by an independent monitor on every output handshake.
module tb_neighbor_window_gen;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst;
  logic       cell_in;
  logic       in_valid;
  logic       in_ready;
  logic       center;
  logic [7:0] neighbors;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       ctr;
    logic [7:0] nbr;
  } exp_t;

  int   vectors       = 0;
  int   miscompares   = 0;
  int   frames_done   = 0;
  int   frame_hs_last = 0;
  exp_t exp_q[$];
  bit   board[ROWS][COLS];

  neighbor_window_gen #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cell_in    (cell_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .center     (center),
    .neighbors  (neighbors),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the board as a 2-D array, neighbours read by offset in the documented bit order.
  function automatic bit model_cell(input int r, input int c);
`ifdef TORUS_WRAP_EN
    return board[(r + ROWS) % ROWS][(c + COLS) % COLS];
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return board[r][c];
`endif
  endfunction

  function automatic logic [7:0] model_nbrs(input int r, input int c);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k] = model_cell(r + dr[k], c + dc[k]);
    return v;
  endfunction

  task automatic set_board(input int kind);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom) : 1'b0;
    if (kind == 0) board[3][3] = 1'b1;
  endtask

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        e.row = 3'(r);
        e.col = 3'(c);
        e.ctr = board[r][c];
        e.nbr = model_nbrs(r, c);
        exp_q.push_back(e);
      end
  endtask

  task automatic load_board(input bit toggle);
    int idx = 0;
    int cyc = 0;
    int not_ready = 0;
    bit phase = 1'b1;
    push_expected();
    while (idx < N && cyc < 1000) begin
      @(posedge clk); #1;
      in_valid = toggle ? phase : 1'b1;
      phase    = !phase;
      cell_in  = board[idx / COLS][idx % COLS];
      @(negedge clk);
      if (!in_ready) not_ready++;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    check("load_accepts", 32'(idx), 32'(N));
    check("load_ready_held", 32'(not_ready), 32'd0);
    // Junk input right after the last accept must be ignored.
    @(posedge clk); #1;
    in_valid = 1'b1;
    cell_in  = 1'($urandom);
    @(negedge clk);
    check("in_ready_after_load", 32'(in_ready), 32'd0);
    check("out_valid_first_scan_cycle", 32'(out_valid), 32'd0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: stall 5 cycles at (1,5), 3: reset at (2,0)
  task automatic run_scan(input int mode);
    int start = frames_done;
    int cyc = 0;
    bit stalled = 1'b0;
    while (frames_done == start && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < 8) cell_in = 1'($urandom);
      else in_valid = 1'b0;
      if (mode == 2 && !stalled && out_valid && out_row == 3'd1 && out_col == 3'd5) begin
        out_ready = 1'b0;
        stalled   = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          check("stall_cell", 32'({out_row, out_col, center, neighbors}),
                32'({3'd1, 3'd5, board[1][5], model_nbrs(1, 5)}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end else if (mode == 3 && out_valid && out_row == 3'd2 && out_col == 3'd0) begin
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_pending_cells", 32'(exp_q.size()), 32'(N - 2 * COLS));
        exp_q.delete();
        return;
      end else begin
        out_ready = (mode == 1) ? 1'($urandom) : 1'b1;
      end
    end
    in_valid = 1'b0;
    check("scan_finished_in_budget", 32'(frames_done != start), 32'd1);
    if (mode == 3) check("abort_point_reached", 32'd0, 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("handshakes_per_frame", 32'(frame_hs_last), 32'(N));
  endtask

  // Monitor: pops and compares on every output handshake, and tracks frame_done placement.
  initial begin : monitor
    bit   last_hs_prev = 1'b0;
    bit   fd_prev = 1'b0;
    int   hs_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_hs_prev = 1'b0;
        fd_prev      = 1'b0;
        hs_cnt       = 0;
      end else begin
        if (fd_prev) check("in_ready_after_done", 32'(in_ready), 32'd1);
        fd_prev = frame_done;
        if (frame_done || last_hs_prev)
          check("frame_done_after_last_hs", 32'({frame_done, last_hs_prev}), 32'd3);
        if (frame_done) begin
          frames_done++;
          frame_hs_last = hs_cnt;
          hs_cnt = 0;
        end
        last_hs_prev = 1'b0;
        if (out_valid && out_ready) begin
          hs_cnt++;
          check("output_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cell r%0d c%0d {row,col,ctr,nbr}", e.row, e.col),
                  32'({out_row, out_col, center, neighbors}), 32'(e));
          end
          if (out_row == 3'(ROWS - 1) && out_col == 3'(COLS - 1)) last_hs_prev = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst       = 1'b1;
    cell_in   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_center", 32'(center), 32'd0);
    check("reset_neighbors", 32'(neighbors), 32'd0);
    check("reset_out_pos", 32'({out_row, out_col}), 32'd0);

    set_board(0); load_board(1'b0); run_scan(0);   // single live cell at (3,3)
    set_board(1); load_board(1'b1); run_scan(0);   // all ones, toggling in_valid
    set_board(2); load_board(1'b0); run_scan(2);   // backpressure at (1,5)
    set_board(2); load_board(1'b1); run_scan(3);   // reset mid-scan at (2,0)
    set_board(2); load_board(1'b0); run_scan(0);   // reload after abort starts at (0,0)
    repeat (3) begin
      set_board(2); load_board(1'($urandom)); run_scan(1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
